// File: rtl/spi_ram_pkg.sv
// Shared opcodes, state encoding and opcode decode helpers for the SPI RAM responder.
// SPI_RAM_FAST_READ_EN adds opcode 0x0B and the DUMMY state.
package spi_ram_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_WRITE     = 8'h02;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
`ifdef SPI_RAM_FAST_READ_EN
        ST_DUMMY,
`endif
        ST_IGNORE
    } spi_state_e;

    // State entered once the 8th opcode bit has arrived.
    function automatic spi_state_e cmd_decode(input logic [7:0] op);
        spi_state_e nxt;
        nxt = ST_IGNORE;
        if (op == CMD_READ || op == CMD_WRITE) nxt = ST_ADDR;
`ifdef SPI_RAM_FAST_READ_EN
        if (op == CMD_FAST_READ) nxt = ST_ADDR;
`endif
        return nxt;
    endfunction

    // State entered after the 24th address bit; only accepted opcodes reach ADDR.
    function automatic spi_state_e addr_done_state(input logic [7:0] op);
        spi_state_e nxt;
        nxt = ST_RD_DATA;
        if (op == CMD_WRITE) nxt = ST_WR_DATA;
`ifdef SPI_RAM_FAST_READ_EN
        if (op == CMD_FAST_READ) nxt = ST_DUMMY;
`endif
        return nxt;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one SPI input with rise/fall pulse generation.
// Edges are suppressed until the chain has filled with real input after reset.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [SYNC_STAGES:0]   r_prime;
    logic                   w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= {SYNC_STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
            r_prime <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_prime <= {r_prime[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A line held at its non-reset level across reset must not look like an edge.
    assign w_valid = r_prime[SYNC_STAGES];
    assign o_q     = r_sync[SYNC_STAGES-1];
    assign o_rise  = w_valid &  o_q & ~r_prev;
    assign o_fall  = w_valid & ~o_q &  r_prev;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 byte RAM responder: READ 0x03, WRITE 0x02, 24-bit address, auto-increment.
// Define SPI_RAM_FAST_READ_EN to accept FAST READ 0x0B with 8 dummy clocks.
module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_in,
    input  logic cs_in,
    input  logic mosi_in,
    output logic miso_out,
    output logic busy_out
);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_cs_q, w_cs_rise, w_cs_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(sclk_in),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_d(cs_in),
        .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_d(mosi_in),
        .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_sclk_q, w_cs_rise, w_mosi_rise, w_mosi_fall};

    spi_state_e         r_state, w_state_nxt;
    logic [4:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_cmd;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_miso;
    logic [7:0]         r_mem [2**ADDR_W];

    logic               w_cs_abort;
    logic               w_last8, w_last24;
    logic [7:0]         w_shift_in;
    logic [ADDR_W-1:0]  w_addr_shift, w_addr_inc;
    logic               w_mem_we;

    // Synchronized cs high ends any transaction and outranks a same-cycle sclk edge.
    assign w_cs_abort   = (r_state != ST_IDLE) && w_cs_q;
    assign w_last8      = (r_bit_cnt == 5'd7);
    assign w_last24     = (r_bit_cnt == 5'd23);
    assign w_shift_in   = {r_shift[6:0], w_mosi_q};
    assign w_addr_shift = {r_addr[ADDR_W-2:0], w_mosi_q};
    assign w_addr_inc   = r_addr + ADDR_W'(1);
    assign w_mem_we     = (r_state == ST_WR_DATA) && !w_cs_q && w_sclk_rise && w_last8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_cs_fall)                w_state_nxt = ST_CMD;
                ST_CMD:  if (w_sclk_rise && w_last8)   w_state_nxt = cmd_decode(w_shift_in);
                ST_ADDR: if (w_sclk_rise && w_last24)  w_state_nxt = addr_done_state(r_cmd);
`ifdef SPI_RAM_FAST_READ_EN
                ST_DUMMY: if (w_sclk_rise && w_last8)  w_state_nxt = ST_RD_DATA;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_miso    <= 1'b0;
        end else if (w_cs_abort) begin
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_cs_fall) begin
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                ST_CMD: if (w_sclk_rise) begin
                    r_shift <= w_shift_in;
                    if (w_last8) begin
                        r_bit_cnt <= '0;
                        r_cmd     <= w_shift_in;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                ST_ADDR: if (w_sclk_rise) begin
                    r_addr <= w_addr_shift;
                    if (w_last24) begin
                        r_bit_cnt <= '0;
                        if (r_cmd == CMD_READ) r_shift <= r_mem[w_addr_shift];
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
`ifdef SPI_RAM_FAST_READ_EN
                ST_DUMMY: if (w_sclk_rise) begin
                    if (w_last8) begin
                        r_bit_cnt <= '0;
                        r_shift   <= r_mem[r_addr];
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
`endif
                ST_RD_DATA: if (w_sclk_fall) begin
                    r_miso <= r_shift[7];
                    if (w_last8) begin
                        // Prefetch the next byte so its MSB follows without a gap.
                        r_bit_cnt <= '0;
                        r_addr    <= w_addr_inc;
                        r_shift   <= r_mem[w_addr_inc];
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        r_shift   <= {r_shift[6:0], 1'b0};
                    end
                end
                ST_WR_DATA: if (w_sclk_rise) begin
                    r_shift <= w_shift_in;
                    if (w_last8) begin
                        r_bit_cnt <= '0;
                        r_addr    <= w_addr_inc;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                default: r_miso <= 1'b0;
            endcase
        end
    end

    // Memory has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_addr] <= w_shift_in;
    end

    assign miso_out = r_miso;
    assign busy_out = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_ram_responder.sv
// Self-checking bench for spi_ram_responder: vector table plus corner-case sequences.
// Build with SPI_RAM_FAST_READ_EN defined to exercise FAST READ expectations.
module tb_spi_ram_responder;

    localparam int HALF = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk_in = 1'b0;
    logic cs_in = 1'b1;
    logic mosi_in = 1'b0;
    logic miso_out;
    logic busy_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tb_mem [1024];
    logic [7:0] exp_q [$];

    spi_ram_responder #(.ADDR_W(10), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .cs_in(cs_in),
        .mosi_in(mosi_in), .miso_out(miso_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n;
        logic [7:0]  d0;
        logic [7:0]  d1;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nb; i--) begin
            mosi_in = tx[i];
            #HALF;
            sclk_in = 1'b1;
            rx[i] = miso_out;
            #HALF;
            sclk_in = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_lo();
        cs_in = 1'b0;
        #(2 * HALF);
    endtask

    task automatic cs_hi();
        #HALF;
        cs_in = 1'b1;
        #30;
        check("busy_drop", {7'd0, busy_out}, 8'h00);
        #100;
    endtask

    task automatic pop_cmp(input string name, input logic [7:0] act);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %02h expected <empty queue>", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] rx;
        logic [9:0] a;
        cs_lo();
        check("busy_high", {7'd0, busy_out}, 8'h01);
        spi_byte(v.cmd, rx);
        check("cmd_miso", rx, 8'h00);
        if (v.cmd != 8'h02 && v.cmd != 8'h03) begin
            for (int i = 0; i < v.n; i++) begin
                exp_q.push_back(8'h00);
                spi_byte(8'hFF, rx);
                pop_cmp("ignore_miso", rx);
            end
        end else begin
            spi_byte(v.addr[23:16], rx);
            spi_byte(v.addr[15:8], rx);
            spi_byte(v.addr[7:0], rx);
            check("addr_miso", rx, 8'h00);
            for (int i = 0; i < v.n; i++) begin
                a = v.addr[9:0] + 10'(i);
                if (v.cmd == 8'h02) begin
                    spi_byte((i == 0) ? v.d0 : v.d1, rx);
                    tb_mem[a] = (i == 0) ? v.d0 : v.d1;
                end else begin
                    exp_q.push_back(tb_mem[a]);
                    spi_byte(8'h00, rx);
                    pop_cmp("read_data", rx);
                end
            end
        end
        cs_hi();
    endtask

    vec_t vecs [9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        vecs[0] = '{8'h02, 24'h000010, 2, 8'hA5, 8'h5A};
        vecs[1] = '{8'h03, 24'h000010, 2, 8'h00, 8'h00};
        vecs[2] = '{8'h02, 24'h0003FF, 2, 8'h11, 8'h22};
        vecs[3] = '{8'h03, 24'h0003FF, 2, 8'h00, 8'h00};
        vecs[4] = '{8'h03, 24'h000000, 1, 8'h00, 8'h00};
        vecs[5] = '{8'h03, 24'hABC010, 1, 8'h00, 8'h00};
        vecs[6] = '{8'h02, 24'h000021, 1, 8'h77, 8'h00};
        vecs[7] = '{8'h9F, 24'h000000, 4, 8'h00, 8'h00};
        vecs[8] = '{8'h03, 24'h000010, 1, 8'h00, 8'h00};

        #32;
        check("rst_miso", {7'd0, miso_out}, 8'h00);
        check("rst_busy", {7'd0, busy_out}, 8'h00);
        rst_n = 1'b1;
        #100;
        check("idle_busy", {7'd0, busy_out}, 8'h00);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Partial opcode must do nothing.
        cs_lo();
        spi_bits(8'h02, 4, rx);
        cs_hi();

        // Aborted second write byte must not reach memory.
        cs_lo();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h20, rx);
        spi_byte(8'h3C, rx);
        tb_mem[10'h020] = 8'h3C;
        spi_bits(8'hFF, 4, rx);
        cs_hi();
        run_vec('{8'h03, 24'h000020, 2, 8'h00, 8'h00});

        // Fast read: opcode, address, one dummy byte, then data.
        cs_lo();
        spi_byte(8'h0B, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'h00, rx);
        check("fast_dummy_miso", rx, 8'h00);
`ifdef SPI_RAM_FAST_READ_EN
        exp_q.push_back(8'hA5);
`else
        exp_q.push_back(8'h00);
`endif
        spi_byte(8'h00, rx);
        pop_cmp("fast_read", rx);
        cs_hi();

        // Reset in the middle of a read, while miso is driving a 1.
        cs_lo();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        mosi_in = 1'b0;
        #HALF;
        sclk_in = 1'b1;
        check("pre_rst_msb", {7'd0, miso_out}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", {7'd0, miso_out}, 8'h00);
        check("midrst_busy", {7'd0, busy_out}, 8'h00);
        #9;
        sclk_in = 1'b0;
        #20;
        rst_n = 1'b1;
        #100;
        spi_byte(8'h03, rx);
        check("no_decode_busy", {7'd0, busy_out}, 8'h00);
        check("no_decode_miso", rx, 8'h00);
        cs_hi();
        run_vec('{8'h03, 24'h000010, 1, 8'h00, 8'h00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
